// File: rtl/pong_ball.sv
// pong_ball: Pong ball engine. The ball moves once per frame (fsync), bounces off the
// top/bottom walls and the two paddles, reports misses with one-cycle score pulses,
// and is re-served through an IDLE -> WAIT -> PLAY -> SCORED state machine. The ball
// is drawn against the raster position (hpos/vpos) with zero latency.
// Optional feature macro: BALL_SPIN_EN -- a paddle hit sets the vertical speed and
// direction from the paddle third struck by the ball centre row.
`timescale 1ns/1ps
module pong_ball #(
  parameter int          HRES      = 1280,
  parameter int          VRES      = 720,
  parameter logic [23:0] COLOR     = 24'h00FF90,
  parameter int          SIZE      = 16,
  parameter int          VEL_X     = 6,
  parameter int          VEL_Y     = 4,
  parameter int          WALL_H    = 20,
  parameter int          PAD_X     = 32,
  parameter int          PAD_W     = 10,
  parameter int          PAD_H     = 120,
  parameter int          SERVE_DLY = 60
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               fsync,
  input  logic               serve,
  input  logic               serve_dir,
  input  logic signed [11:0] lpad_top,
  input  logic signed [11:0] rpad_top,
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  output logic [2:0][7:0]    pixel,
  output logic               active,
  output logic               score_l,
  output logic               score_r,
  output logic signed [11:0] ball_x,
  output logic signed [11:0] ball_y,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_PLAY   = 2'd2,
    S_SCORED = 2'd3
  } state_t;

  localparam int CNT_W = (SERVE_DLY > 1) ? $clog2(SERVE_DLY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DLY - 1);

  // All position arithmetic is done 13-bit signed so moves past the screen edge never wrap.
  localparam logic signed [12:0] SIZE_S    = 13'(SIZE);
  localparam logic signed [12:0] STEP_X    = 13'(VEL_X);
  localparam logic signed [12:0] PAD_H_S   = 13'(PAD_H);
  localparam logic signed [12:0] OUT_LEFT  = 13'(-SIZE);
  localparam logic signed [12:0] OUT_RIGHT = 13'(HRES);
  localparam logic signed [12:0] Y_TOP     = 13'(WALL_H);
  localparam logic signed [12:0] Y_BOT     = 13'(VRES - WALL_H - SIZE);
  localparam logic signed [12:0] FACE_L    = 13'(PAD_X + PAD_W);
  localparam logic signed [12:0] FACE_R    = 13'(HRES - PAD_X - PAD_W);
  localparam logic signed [11:0] X_RHIT    = 12'(HRES - PAD_X - PAD_W - SIZE);
  localparam logic signed [11:0] X_CTR     = 12'((HRES - SIZE) / 2);
  localparam logic signed [11:0] Y_CTR     = 12'((VRES - SIZE) / 2);
  localparam logic [11:0]        VY_BASE   = 12'(VEL_Y);

  state_t             state_q;
  logic signed [11:0] x_q, y_q;
  logic               dx_q;        // 1 = moving right
  logic               dy_q;        // 1 = moving down
  logic [11:0]        vy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               score_l_q, score_r_q;

  logic signed [12:0] x_s, y_s, lp_s, rp_s, vy_s, nx_s, ny_s, h_s, v_s;
  logic signed [11:0] x_d, y_d;
  logic               dx_d, dy_d;
  logic [11:0]        vy_d;
  logic               hit_l, hit_r, miss_l, miss_r;

  assign x_s  = {x_q[11], x_q};
  assign y_s  = {y_q[11], y_q};
  assign lp_s = {lpad_top[11], lpad_top};
  assign rp_s = {rpad_top[11], rpad_top};
  assign vy_s = {1'b0, vy_q};
  assign h_s  = {hpos[11], hpos};
  assign v_s  = {vpos[11], vpos};

`ifdef BALL_SPIN_EN
  localparam logic signed [12:0] CTR_OFF = 13'(SIZE / 2);
  localparam logic signed [12:0] THIRD   = 13'(PAD_H / 3);
  localparam logic signed [12:0] THIRD2  = 13'(2 * (PAD_H / 3));
  localparam logic [11:0]        VY_FAST = 12'(2 * VEL_Y);
  logic signed [12:0] rel_s;
  // Ball centre row relative to the top of the paddle being struck.
  assign rel_s = y_s + CTR_OFF - (hit_l ? lp_s : rp_s);
`endif

  // Candidate motion for this frame: raw step, paddle bounce, wall clamp, miss detection.
  always_comb begin
    nx_s  = dx_q ? (x_s + STEP_X) : (x_s - STEP_X);
    ny_s  = dy_q ? (y_s + vy_s) : (y_s - vy_s);
    // Paddle contact is judged on the pre-move row, crossing on the face column.
    hit_l = !dx_q && (x_s >= FACE_L) && (nx_s < FACE_L) &&
            (y_s + SIZE_S > lp_s) && (y_s < lp_s + PAD_H_S);
    hit_r = dx_q && (x_s + SIZE_S <= FACE_R) && (nx_s + SIZE_S > FACE_R) &&
            (y_s + SIZE_S > rp_s) && (y_s < rp_s + PAD_H_S);
    miss_r = !hit_l && !hit_r && (nx_s <= OUT_LEFT);
    miss_l = !hit_l && !hit_r && (nx_s >= OUT_RIGHT);

    x_d  = nx_s[11:0];
    dx_d = dx_q;
    if (hit_l) begin
      x_d  = FACE_L[11:0];
      dx_d = 1'b1;
    end else if (hit_r) begin
      x_d  = X_RHIT;
      dx_d = 1'b0;
    end

    y_d  = ny_s[11:0];
    dy_d = dy_q;
    if (ny_s < Y_TOP) begin
      y_d  = Y_TOP[11:0];
      dy_d = 1'b1;
    end else if (ny_s > Y_BOT) begin
      y_d  = Y_BOT[11:0];
      dy_d = 1'b0;
    end

    vy_d = vy_q;
`ifdef BALL_SPIN_EN
    if (hit_l || hit_r) begin
      if (rel_s < THIRD) begin
        vy_d = VY_FAST;
        dy_d = 1'b0;
      end else if (rel_s >= THIRD2) begin
        vy_d = VY_FAST;
        dy_d = 1'b1;
      end else begin
        vy_d = VY_BASE;
      end
    end
`endif
  end

  // Serve/play state machine, ball state and registered score pulses.
  always_ff @(posedge pixel_clk) begin
    score_l_q <= 1'b0;
    score_r_q <= 1'b0;
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= X_CTR;
      y_q     <= Y_CTR;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      vy_q    <= VY_BASE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (serve) begin
            state_q <= S_WAIT;
            dx_q    <= serve_dir;
            dy_q    <= 1'b1;
            vy_q    <= VY_BASE;
            cnt_q   <= '0;
          end
        end
        S_WAIT: begin
          if (fsync) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= S_PLAY;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_PLAY: begin
          if (fsync) begin
            if (miss_l || miss_r) begin
              state_q   <= S_SCORED;
              score_l_q <= miss_l;
              score_r_q <= miss_r;
            end else begin
              x_q  <= x_d;
              y_q  <= y_d;
              dx_q <= dx_d;
              dy_q <= dy_d;
              vy_q <= vy_d;
            end
          end
        end
        default: begin
          if (fsync) begin
            state_q <= S_IDLE;
            x_q     <= X_CTR;
            y_q     <= Y_CTR;
          end
        end
      endcase
    end
  end

  // Zero-latency draw: ball square is opaque except while a point is being scored.
  assign active = (state_q != S_SCORED) &&
                  (h_s >= x_s) && (h_s < x_s + SIZE_S) &&
                  (v_s >= y_s) && (v_s < y_s + SIZE_S);
  assign pixel   = active ? COLOR : 24'h0;
  assign ball_x  = x_q;
  assign ball_y  = y_q;
  assign state   = state_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;

endmodule

// File: tb/tb_pong_ball.sv
// tb_pong_ball: scoreboard bench for pong_ball. A frame-level behavioural model pushes the
// expected {state, x, y, score_l, score_r} at each fsync; the scenario tasks pop and compare
// after the edge, alongside hand-derived trajectory checkpoints.
`timescale 1ns/1ps
module tb_pong_ball;
  localparam int HRES = 1280, VRES = 720, SIZE = 16, VEL_X = 6, VEL_Y = 4, WALL_H = 20;
  localparam int PAD_X = 32, PAD_W = 10, PAD_H = 120, SERVE_DLY = 60;
  localparam int LFACE = PAD_X + PAD_W;
  localparam int RFACE = HRES - PAD_X - PAD_W;
  localparam int XC = (HRES - SIZE) / 2;
  localparam int YC = (VRES - SIZE) / 2;

  localparam int HP [6] = '{640, 632, 631, 647, 648, 640};
  localparam int VP [6] = '{360, 352, 352, 367, 360, 368};
  localparam bit EA [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  logic               pixel_clk = 1'b0;
  logic               rst = 1'b0, fsync = 1'b0, serve = 1'b0, serve_dir = 1'b0;
  logic signed [11:0] lpad_top = '0, rpad_top = '0, hpos = '0, vpos = '0;
  logic [2:0][7:0]    pixel;
  logic               active, score_l, score_r;
  logic signed [11:0] ball_x, ball_y;
  logic [1:0]         state;

  pong_ball dut (
    .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .serve(serve), .serve_dir(serve_dir),
    .lpad_top(lpad_top), .rpad_top(rpad_top), .hpos(hpos), .vpos(vpos),
    .pixel(pixel), .active(active), .score_l(score_l), .score_r(score_r),
    .ball_x(ball_x), .ball_y(ball_y), .state(state)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct packed {
    logic [1:0]  st;
    logic [11:0] x;
    logic [11:0] y;
    logic        sl;
    logic        sr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_st, m_x, m_y, m_dx, m_dy, m_vy, m_cnt;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic model_reset();
    m_st = 0; m_x = XC; m_y = YC; m_dx = 1; m_dy = 1; m_vy = VEL_Y; m_cnt = 0;
  endtask

  task automatic model_serve(input int dir);
    m_st = 1; m_dx = dir; m_dy = 1; m_vy = VEL_Y; m_cnt = 0;
  endtask

  // One frame of ball behaviour; pushes what the DUT must show right after this fsync.
  task automatic model_fsync();
    int   nx, ny, lp, rp;
    bit   hit;
    exp_t e;
    e.sl = 1'b0; e.sr = 1'b0;
    lp = lpad_top; rp = rpad_top;
    case (m_st)
      1: begin
        m_cnt++;
        if (m_cnt == SERVE_DLY) begin m_st = 2; m_cnt = 0; end
      end
      2: begin
        nx = (m_dx == 1) ? m_x + VEL_X : m_x - VEL_X;
        ny = (m_dy == 1) ? m_y + m_vy : m_y - m_vy;
        hit = 1'b0;
        if (m_dx == 0 && m_x >= LFACE && nx < LFACE && m_y + SIZE > lp && m_y < lp + PAD_H) begin
          nx = LFACE; m_dx = 1; hit = 1'b1;
        end else if (m_dx == 1 && m_x + SIZE <= RFACE && nx + SIZE > RFACE &&
                     m_y + SIZE > rp && m_y < rp + PAD_H) begin
          nx = RFACE - SIZE; m_dx = 0; hit = 1'b1;
        end
        if (!hit && nx <= -SIZE) begin
          m_st = 3; e.sr = 1'b1;
        end else if (!hit && nx >= HRES) begin
          m_st = 3; e.sl = 1'b1;
        end else begin
          if (ny < WALL_H) begin ny = WALL_H; m_dy = 1; end
          else if (ny + SIZE > VRES - WALL_H) begin ny = VRES - WALL_H - SIZE; m_dy = 0; end
          m_x = nx; m_y = ny;
        end
      end
      3: begin m_st = 0; m_x = XC; m_y = YC; end
      default: ;
    endcase
    e.st = m_st[1:0]; e.x = m_x[11:0]; e.y = m_y[11:0];
    sb.push_back(e);
  endtask

  task automatic do_frame();
    repeat (3) tick();
    model_fsync();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
  endtask

  // Serve request plus the full launch delay; the model is advanced to PLAY directly.
  task automatic launch(input bit dir);
    serve_dir = dir; serve = 1'b1;
    tick();
    serve = 1'b0;
    model_serve(int'(dir));
    repeat (SERVE_DLY) begin
      repeat (3) tick();
      fsync = 1'b1; tick(); fsync = 1'b0;
    end
    m_st = 2; m_cnt = 0;
  endtask

  task automatic test_reset();
    exp_t got, e;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    n_checks++;
    if (ball_x !== 12'sd632) begin n_fail++; $display("FAIL reset_x: got %0d want 632", ball_x); end
    n_checks++;
    if (ball_y !== 12'sd352) begin n_fail++; $display("FAIL reset_y: got %0d want 352", ball_y); end
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++;
    if ({score_l, score_r} !== 2'b00) begin
      n_fail++; $display("FAIL reset_scores: got %b%b want 00", score_l, score_r);
    end
    for (int i = 0; i < 6; i++) begin
      hpos = 12'(HP[i]); vpos = 12'(VP[i]);
      #1;
      n_checks++;
      if ({active, pixel} !== {EA[i], (EA[i] ? 24'h00FF90 : 24'h000000)}) begin
        n_fail++;
        $display("FAIL raster[%0d] h=%0d v=%0d: got active=%b pixel=%h want active=%b", i, HP[i], VP[i], active, pixel, EA[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      do_frame();
      e = sb.pop_front(); got = {state, ball_x, ball_y, score_l, score_r};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL idle_frame[%0d]: got st=%0d x=%0d y=%0d want st=%0d x=%0d y=%0d", i, got.st, $signed(got.x), $signed(got.y), e.st, $signed(e.x), $signed(e.y));
      end
    end
  endtask

  task automatic test_serve();
    exp_t got, e;
    serve_dir = 1'b1; serve = 1'b1;
    tick();
    model_serve(1);
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL serve_to_wait: got %0d want 1", state); end
    for (int i = 0; i < SERVE_DLY + 1; i++) begin
      if (i == 10) serve = 1'b0;
      do_frame();
      e = sb.pop_front(); got = {state, ball_x, ball_y, score_l, score_r};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL serve_frame[%0d]: got st=%0d x=%0d y=%0d want st=%0d x=%0d y=%0d", i, got.st, $signed(got.x), $signed(got.y), e.st, $signed(e.x), $signed(e.y));
      end
      if (i == SERVE_DLY - 2) begin
        n_checks++;
        if (state !== 2'd1) begin n_fail++; $display("FAIL wait_59th: got %0d want 1", state); end
      end
      if (i == SERVE_DLY - 1) begin
        n_checks++;
        if ({state, ball_x} !== {2'd2, 12'sd632}) begin
          n_fail++; $display("FAIL launch_60th: got st=%0d x=%0d want st=2 x=632", state, ball_x);
        end
      end
    end
    n_checks++;
    if (ball_x !== 12'sd638 || ball_y !== 12'sd356) begin
      n_fail++; $display("FAIL first_move: got x=%0d y=%0d want x=638 y=356", ball_x, ball_y);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; fsync = 1'b1; serve = 1'b1;
    tick();
    rst = 1'b0; fsync = 1'b0; serve = 1'b0;
    model_reset();
    n_checks++;
    if ({state, ball_x, ball_y, score_l, score_r} !== {2'd0, 12'sd632, 12'sd352, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_mid: got st=%0d x=%0d y=%0d sl=%b sr=%b want st=0 x=632 y=352 sl=0 sr=0", state, ball_x, ball_y, score_l, score_r);
    end
    tick();
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL reset_mid_hold: got %0d want 0", state); end
  endtask

  task automatic test_miss_right();
    exp_t got, e;
    lpad_top = '0; rpad_top = '0; hpos = 12'sd1276; vpos = 12'sd600;
    launch(1'b1);
    n_checks++;
    if (state !== 2'd2) begin n_fail++; $display("FAIL mr_launch: got %0d want 2", state); end
    for (int k = 1; k <= 108; k++) begin
      do_frame();
      e = sb.pop_front(); got = {state, ball_x, ball_y, score_l, score_r};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL mr_frame[%0d]: got st=%0d x=%0d y=%0d sl=%b want st=%0d x=%0d y=%0d sl=%b", k, got.st, $signed(got.x), $signed(got.y), got.sl, e.st, $signed(e.x), $signed(e.y), e.sl);
      end
      if (k == 107) begin
        n_checks++;
        if (ball_x !== 12'sd1274 || ball_y !== 12'sd592 || active !== 1'b1) begin
          n_fail++; $display("FAIL mr_edge: got x=%0d y=%0d active=%b want x=1274 y=592 active=1", ball_x, ball_y, active);
        end
      end
      if (k == 108) begin
        n_checks++;
        if ({state, score_l, score_r, ball_x} !== {2'd3, 2'b10, 12'sd1274}) begin
          n_fail++; $display("FAIL mr_score: got st=%0d sl=%b sr=%b x=%0d want st=3 sl=1 sr=0 x=1274", state, score_l, score_r, ball_x);
        end
      end
    end
    tick();
    n_checks++;
    if ({state, score_l, active} !== {2'd3, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL mr_pulse_end: got st=%0d sl=%b active=%b want st=3 sl=0 active=0", state, score_l, active);
    end
    do_frame();
    e = sb.pop_front(); got = {state, ball_x, ball_y, score_l, score_r};
    n_checks++;
    if (got !== e || state !== 2'd0 || ball_x !== 12'sd632) begin
      n_fail++; $display("FAIL mr_recentre: got st=%0d x=%0d y=%0d want st=0 x=632 y=352", got.st, $signed(got.x), $signed(got.y));
    end
  endtask

  task automatic test_rally();
    exp_t got, e;
    lpad_top = 12'sd600; rpad_top = 12'sd150;
    launch(1'b0);
    n_checks++;
    if (state !== 2'd2) begin n_fail++; $display("FAIL rally_launch: got %0d want 2", state); end
    for (int k = 1; k <= 296; k++) begin
      do_frame();
      e = sb.pop_front(); got = {state, ball_x, ball_y, score_l, score_r};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL rally_frame[%0d]: got st=%0d x=%0d y=%0d want st=%0d x=%0d y=%0d", k, got.st, $signed(got.x), $signed(got.y), e.st, $signed(e.x), $signed(e.y));
      end
      if (k == 83 || k == 84 || k == 85) begin
        n_checks++;
        if (ball_y !== ((k == 85) ? 12'sd680 : 12'sd684)) begin
          n_fail++; $display("FAIL bottom_wall[%0d]: got y=%0d want %0d", k, ball_y, (k == 85) ? 680 : 684);
        end
      end
      if (k == 98) begin
        n_checks++;
        if (ball_x !== 12'sd44 || ball_y !== 12'sd628) begin
          n_fail++; $display("FAIL lpad_approach: got x=%0d y=%0d want x=44 y=628", ball_x, ball_y);
        end
      end
      if (k == 99) begin
        n_checks++;
        if (ball_x !== 12'sd42) begin n_fail++; $display("FAIL lpad_hit: got x=%0d want 42", ball_x); end
      end
      if (k == 100) begin
        n_checks++;
        if (ball_x !== 12'sd48) begin n_fail++; $display("FAIL lpad_rebound: got x=%0d want 48", ball_x); end
      end
      if (k >= 249 && k <= 252) begin
        n_checks++;
        if (ball_y !== ((k == 249 || k == 252) ? 12'sd24 : 12'sd20)) begin
          n_fail++; $display("FAIL top_wall[%0d]: got y=%0d want %0d", k, ball_y, (k == 249 || k == 252) ? 24 : 20);
        end
      end
      if (k == 296) begin
        n_checks++;
        if (ball_x !== 12'sd1222 || ball_y !== 12'sd200) begin
          n_fail++; $display("FAIL rpad_hit: got x=%0d y=%0d want x=1222 y=200", ball_x, ball_y);
        end
      end
    end
  endtask

  task automatic test_miss_left();
    exp_t got, e;
    lpad_top = '0; hpos = '0; vpos = 12'sd350;
    for (int m = 1; m <= 207; m++) begin
      do_frame();
      e = sb.pop_front(); got = {state, ball_x, ball_y, score_l, score_r};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL ml_frame[%0d]: got st=%0d x=%0d y=%0d sr=%b want st=%0d x=%0d y=%0d sr=%b", m, got.st, $signed(got.x), $signed(got.y), got.sr, e.st, $signed(e.x), $signed(e.y), e.sr);
      end
      if (m == 206) begin
        n_checks++;
        if (ball_x !== -12'sd14 || ball_y !== 12'sd348 || active !== 1'b1) begin
          n_fail++; $display("FAIL ml_edge: got x=%0d y=%0d active=%b want x=-14 y=348 active=1", ball_x, ball_y, active);
        end
      end
      if (m == 207) begin
        n_checks++;
        if ({state, score_l, score_r, ball_x} !== {2'd3, 2'b01, -12'sd14}) begin
          n_fail++; $display("FAIL ml_score: got st=%0d sl=%b sr=%b x=%0d want st=3 sl=0 sr=1 x=-14", state, score_l, score_r, ball_x);
        end
        n_checks++;
        if (active !== 1'b0 || pixel !== 24'h0) begin
          n_fail++; $display("FAIL ml_hidden: got active=%b pixel=%h want active=0 pixel=000000", active, pixel);
        end
      end
    end
    tick();
    n_checks++;
    if ({state, score_r} !== {2'd3, 1'b0}) begin
      n_fail++; $display("FAIL ml_pulse_end: got st=%0d sr=%b want st=3 sr=0", state, score_r);
    end
    do_frame();
    e = sb.pop_front(); got = {state, ball_x, ball_y, score_l, score_r};
    n_checks++;
    if (got !== e || ball_x !== 12'sd632 || ball_y !== 12'sd352) begin
      n_fail++; $display("FAIL ml_recentre: got st=%0d x=%0d y=%0d want st=0 x=632 y=352", got.st, $signed(got.x), $signed(got.y));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_serve();
    test_reset_mid();
    test_miss_right();
    test_rally();
    test_miss_left();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
